// File: rtl/pipelined_decode_ctrl.sv
// pipelined_decode_ctrl: registered ID/EX decoder with stall hold, flush bubbles and illegal-opcode counting.
// Define CTRL_MUL_EN to add the multi-cycle MUL (opcode 2) with its MULTI state and busy output.
module pipelined_decode_ctrl #(
    parameter int OPC_W      = 6,
    parameter int EXE_W      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [EXE_W-1:0] exe_cmd,
    output logic [1:0]       branch_type,
    output logic             mem_read,
    output logic             mem_write,
    output logic             writeback_en,
    output logic             is_immediate,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);
    typedef struct packed {
        logic [EXE_W-1:0] exe;
        logic [1:0]       br;
        logic             mr;
        logic             mw;
        logic             wb;
        logic             imm;
    } ctrl_t;

    ctrl_t            dec, ctrl_q, ctrl_d;
    logic             dec_ill;
    logic             valid_q, valid_d, busy_q, busy_d, ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef CTRL_MUL_EN
    typedef enum logic {RUN, MULTI} state_t;
    localparam int MC_W = MUL_CYCLES > 1 ? $clog2(MUL_CYCLES) : 1;
    state_t           state_q, state_d;
    logic [MC_W-1:0]  mc_q, mc_d;
    logic             dec_mul;
`endif

    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
`ifdef CTRL_MUL_EN
        dec_mul = 1'b0;
`endif
        case (32'(opcode))
            0:  ;
            1:  begin dec.exe = EXE_W'(4'b0000); dec.wb = 1'b1; end
            3:  begin dec.exe = EXE_W'(4'b0010); dec.wb = 1'b1; end
            5:  begin dec.exe = EXE_W'(4'b0100); dec.wb = 1'b1; end
            6:  begin dec.exe = EXE_W'(4'b0101); dec.wb = 1'b1; end
            7:  begin dec.exe = EXE_W'(4'b0110); dec.wb = 1'b1; end
            8:  begin dec.exe = EXE_W'(4'b0111); dec.wb = 1'b1; end
            9:  begin dec.exe = EXE_W'(4'b1000); dec.wb = 1'b1; end
            10: begin dec.exe = EXE_W'(4'b1011); dec.wb = 1'b1; end
            11: begin dec.exe = EXE_W'(4'b1001); dec.wb = 1'b1; end
            12: begin dec.exe = EXE_W'(4'b1010); dec.wb = 1'b1; end
            32: begin dec.imm = 1'b1; dec.wb = 1'b1; end
            33: begin dec.exe = EXE_W'(4'b0010); dec.imm = 1'b1; dec.wb = 1'b1; end
            36: begin dec.imm = 1'b1; dec.mr = 1'b1; dec.wb = 1'b1; end
            37: begin dec.imm = 1'b1; dec.mw = 1'b1; end
            40: dec.br = 2'b01;
            41: dec.br = 2'b10;
            42: dec.br = 2'b11;
`ifdef CTRL_MUL_EN
            2:  begin dec.exe = EXE_W'(4'b1100); dec.wb = 1'b1; dec_mul = 1'b1; end
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ill_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef CTRL_MUL_EN
        state_d = state_q;
        mc_d    = mc_q;
`endif
        if (flush) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
`ifdef CTRL_MUL_EN
            state_d = RUN;
`endif
        end else if (stall) begin
            // everything holds; only the illegal pulse drops
        end
`ifdef CTRL_MUL_EN
        else if (state_q == MULTI) begin
            if (mc_q == MC_W'(1)) begin
                valid_d    = 1'b1;
                ctrl_d     = '0;
                ctrl_d.exe = EXE_W'(4'b1100);
                ctrl_d.wb  = 1'b1;
                busy_d     = 1'b0;
                state_d    = RUN;
            end else begin
                mc_d = mc_q - 1'b1;
            end
        end else if (instr_valid && dec_mul && MUL_CYCLES > 1) begin
            state_d = MULTI;
            mc_d    = MC_W'(MUL_CYCLES - 1);
            valid_d = 1'b0;
            ctrl_d  = '0;
            busy_d  = 1'b1;
        end
`endif
        else begin
            valid_d = instr_valid;
            ctrl_d  = instr_valid ? dec : '0;
            busy_d  = 1'b0;
            ill_d   = instr_valid && dec_ill;
            cnt_d   = (instr_valid && dec_ill && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef CTRL_MUL_EN
            state_q <= RUN;
            mc_q    <= '0;
`endif
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
`ifdef CTRL_MUL_EN
            state_q <= state_d;
            mc_q    <= mc_d;
`endif
        end
    end

    assign out_valid     = valid_q;
    assign exe_cmd       = ctrl_q.exe;
    assign branch_type   = ctrl_q.br;
    assign mem_read      = ctrl_q.mr;
    assign mem_write     = ctrl_q.mw;
    assign writeback_en  = ctrl_q.wb;
    assign is_immediate  = ctrl_q.imm;
    assign busy          = busy_q;
    assign illegal       = ill_q;
    assign illegal_count = cnt_q;
endmodule
